// File: rtl/ex_pkg.sv
// ex_pkg: shared opcodes, result classes, divider states and widths for the EX stage
package ex_pkg;
  localparam int ALU_OP_W = 8;
  localparam int ALU_SEL_W = 3;
  localparam int REG_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP = 8'b0010_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;
  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_e;
endpackage

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle, signed or unsigned
import ex_pkg::*;
module ex_div (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [REG_W-1:0]   opdata1,
  input  logic [REG_W-1:0]   opdata2,
  input  logic               start,
  output logic [2*REG_W-1:0] result,
  output logic               ready
);
  div_state_e state;
  logic [4:0] cnt;
  logic [REG_W-1:0] rem, quo, dvs, mag1, mag2, r_next, q_next;
  logic [REG_W:0] tmp, diff;
  logic neg1, neg2, neg_q, neg_r;
  assign neg1 = signed_div & opdata1[REG_W-1];
  assign neg2 = signed_div & opdata2[REG_W-1];
  assign mag1 = neg1 ? -opdata1 : opdata1;
  assign mag2 = neg2 ? -opdata2 : opdata2;
  assign tmp = {rem, quo[REG_W-1]};
  assign diff = tmp - {1'b0, dvs};
  assign r_next = diff[REG_W] ? tmp[REG_W-1:0] : diff[REG_W-1:0];
  assign q_next = {quo[REG_W-2:0], ~diff[REG_W]};
  assign ready = state == DIV_END;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        DIV_FREE: if (start) begin
          if (opdata2 == '0) state <= DIV_BY_ZERO;
          else begin
            state <= DIV_ON;
            cnt <= '0;
            rem <= '0;
            quo <= mag1;
            dvs <= mag2;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
          end
        end
        DIV_BY_ZERO: begin
          state <= DIV_END;
          result <= '0;
        end
        DIV_ON: begin
          rem <= r_next;
          quo <= q_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DIV_END;
            result <= {neg_r ? -r_next : r_next, neg_q ? -q_next : q_next};
          end
        end
        default: if (!start) state <= DIV_FREE;
      endcase
    end
  end
endmodule

// File: rtl/ex.sv
// ex: EX stage ALU with stall logic; optional iterative divider under EX_DIV_EN
import ex_pkg::*;
module ex (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o
);
  logic [REG_W-1:0] logic_res, shift_res, arith_res, addend, sum, wdata;
  logic [2*REG_W-1:0] hilo;
  logic is_div, is_sub, ov, ov_kill, div_kill, stall, whilo;
  assign is_div = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
  assign is_sub = aluop_i == EXE_SUB_OP || aluop_i == EXE_SUBU_OP;
  assign addend = is_sub ? ~reg2_i : reg2_i;
  assign sum = reg1_i + addend + {{(REG_W-1){1'b0}}, is_sub};
  assign ov = reg1_i[REG_W-1] == addend[REG_W-1] && sum[REG_W-1] != reg1_i[REG_W-1];
  assign ov_kill = ov && (aluop_i == EXE_ADD_OP || aluop_i == EXE_SUB_OP);
  always_comb begin
    logic_res = aluop_i == EXE_AND_OP ? reg1_i & reg2_i :
                aluop_i == EXE_OR_OP  ? reg1_i | reg2_i :
                aluop_i == EXE_XOR_OP ? reg1_i ^ reg2_i :
                aluop_i == EXE_NOR_OP ? ~(reg1_i | reg2_i) : '0;
    shift_res = aluop_i == EXE_SLL_OP ? reg2_i << reg1_i[4:0] :
                aluop_i == EXE_SRL_OP ? reg2_i >> reg1_i[4:0] :
                aluop_i == EXE_SRA_OP ? REG_W'($signed(reg2_i) >>> reg1_i[4:0]) : '0;
    arith_res = aluop_i == EXE_SLT_OP  ? {{(REG_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)} :
                aluop_i == EXE_SLTU_OP ? {{(REG_W-1){1'b0}}, reg1_i < reg2_i} :
                (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDU_OP || is_sub) ? sum : '0;
    wdata = alusel_i == EXE_RES_LOGIC ? logic_res :
            alusel_i == EXE_RES_SHIFT ? shift_res :
            alusel_i == EXE_RES_ARITH ? arith_res : '0;
  end
`ifdef EX_DIV_EN
  logic ready;
  logic [2*REG_W-1:0] result;
  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .signed_div(aluop_i == EXE_DIV_OP),
    .opdata1   (reg1_i),
    .opdata2   (reg2_i),
    .start     (is_div & ~ready),
    .result    (result),
    .ready     (ready)
  );
  assign stall = is_div & ~ready;
  assign whilo = is_div & ready;
  assign hilo = whilo ? result : '0;
  assign div_kill = 1'b0;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign stall = 1'b0;
  assign whilo = 1'b0;
  assign hilo = '0;
  assign div_kill = is_div;
`endif
  assign wd_o = rst ? '0 : wd_i;
  assign wreg_o = rst || ov_kill || div_kill ? 1'b0 : wreg_i;
  assign wdata_o = rst ? '0 : wdata;
  assign hi_o = rst ? '0 : hilo[2*REG_W-1:REG_W];
  assign lo_o = rst ? '0 : hilo[REG_W-1:0];
  assign whilo_o = ~rst & whilo;
  assign stallreq_o = ~rst & stall;
endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 aluop_i  in  8  operation code, `AluOpBus.
REQ-004 alusel_i  in  3  result class (logic/shift/arith/nop), `AluSelBus.
REQ-005 reg1_i, reg2_i  in  32 each  source operands.
REQ-006 wd_i  in  5  destination register address; wreg_i  in  1  write enable.
REQ-007 wd_o  out  5, wreg_o  out  1, wdata_o  out  32  register writeback to EX/MEM register.
REQ-008 hi_o, lo_o  out  32 each, whilo_o  out  1  HI/LO writeback.
REQ-009 stallreq_o  out  1  stall request to pipeline control; bit 3 of the stall bus is EX.

Function
REQ-010 Logic class: AND, OR, XOR, NOR of reg1_i, reg2_i; combinational, zero latency.
REQ-011 Shift class: SLL, SRL, SRA of reg2_i by reg1_i[4:0]; SRA sign-fills.
REQ-012 Arith class: ADD, ADDU, SUB, SUBU, SLT (signed), SLTU (unsigned); 32-bit wrap.
REQ-013 ADD/SUB signed overflow forces wreg_o=0; otherwise wreg_o=wreg_i, wd_o=wd_i.
REQ-014 NOP or unknown alusel_i: wdata_o=0.
REQ-015 whilo_o=1 only in the cycle a DIV/DIVU result is ready; hi_o=remainder, lo_o=quotient; otherwise hi_o=lo_o=0, whilo_o=0.
REQ-016 DIV/DIVU iterative, one quotient bit per cycle; divider states FREE, BY_ZERO, ON, END.
REQ-017 FREE: start with divisor 0 -> BY_ZERO; start with nonzero divisor -> ON, counter=0, operands latched.
REQ-018 BY_ZERO -> END next edge, result {hi,lo}=0.
REQ-019 ON: 32 restoring shift-subtract steps, counter 0..31; after step 31 -> END.
REQ-020 DIV signed: operate on magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-021 END: ready=1, result held; start deasserted -> FREE.
REQ-022 stallreq_o=1 while a DIV/DIVU is in EX and divider not in END; 0 otherwise.
REQ-023 Latency (cycle 0 = first EX cycle): nonzero divisor ready in cycle 33, stallreq_o high cycles 0-32; zero divisor ready in cycle 2, stallreq_o high cycles 0-1.
REQ-024 Back-to-back divides: second divide enters FREE via END->FREE, then restarts; no result from first reused.
REQ-025 Divide operands latched at start; upstream input changes during ON ignored.

Reset
REQ-026 rst=1: wd_o=0, wreg_o=0, wdata_o=0, hi_o=0, lo_o=0, whilo_o=0, stallreq_o=0.
REQ-027 rst=1: divider -> FREE, counter=0, ready=0, result=0; applies mid-operation, partial result discarded.

Configuration
REQ-028 Macro EX_DIV_EN defined: divider instantiated, REQ-016..REQ-025 apply.
REQ-029 EX_DIV_EN undefined: no divider; DIV/DIVU give stallreq_o=0, whilo_o=0, hi_o=lo_o=0, wreg_o=0.

Structure
REQ-030 Opcode constants (EXE_*_OP incl. EXE_DIV_OP, EXE_DIVU_OP), class codes, divider state codes, widths in shared precompiled.v.
REQ-031 Divider is sub-module div (clk, rst, signed_div, opdata1, opdata2, start, result 64, ready); ex keeps ALU and stall logic.

Verification
REQ-032 ADD 0x7FFFFFFF+1 -> wreg_o=0; ADDU same -> wdata_o=0x80000000, wreg_o=1.
REQ-033 SRA reg2=0x80000000, reg1=4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-034 DIVU 100/7 held -> stallreq_o high 33 cycles, cycle 33 lo_o=14, hi_o=2, whilo_o=1.
REQ-035 DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 5/0 -> stallreq_o 2 cycles, hi_o=lo_o=0, whilo_o=1.
REQ-036 rst at ON counter=10 -> next cycle FREE, stallreq_o=0; reissue DIVU 100/7 -> correct result in 34 cycles.
REQ-037 Build without EX_DIV_EN: DIVU 100/7 -> stallreq_o never 1, whilo_o=0.
